// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample path: reader FSM states,
// flash word width and the default sample-region bounds.
package audio_pkg;

  // Flash word reader FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ      = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } reader_state_t;

  localparam int FLASH_WORD_W = 32;
  localparam int FLASH_ADDR_W = 23;

  // Default sample region, shared with audio_control and the top level
  localparam logic [FLASH_ADDR_W-1:0] START_ADDR = 23'h000000;
  localparam logic [FLASH_ADDR_W-1:0] END_ADDR   = 23'h07FFFF;

  // Byte enable used for every flash read: always the full word
  function automatic logic [3:0] full_word_byteenable();
    return 4'hF;
  endfunction

endpackage

// File: rtl/flash_word_reader_if.sv
// Avalon-MM read port between the word reader (master) and the flash
// controller (slave).
interface flash_word_reader_if #(
  parameter int ADDR_W = 23
);
  import audio_pkg::*;

  logic                    flash_read;
  logic [ADDR_W-1:0]       flash_address;
  logic [3:0]              flash_byteenable;
  logic                    flash_waitrequest;
  logic [FLASH_WORD_W-1:0] flash_readdata;
  logic                    flash_readdatavalid;

  modport master (
    output flash_read,
    output flash_address,
    output flash_byteenable,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_read,
    input  flash_address,
    input  flash_byteenable,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );

endinterface

// File: rtl/wrap_addr_counter.sv
// Up/down word-address counter confined to [START_ADDR, END_ADDR].
// Stepping past either end wraps to the other; load beats step.
module wrap_addr_counter
  import audio_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = audio_pkg::START_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR   = audio_pkg::END_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              up,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_next_count;

  // Next count: load, wrapped step, or hold
  always_comb begin
    w_next_count = r_count;
    if (load) begin
      w_next_count = load_val;
    end else if (step) begin
      if (up) begin
        w_next_count = (r_count == END_ADDR) ? START_ADDR : (r_count + ONE);
      end else begin
        w_next_count = (r_count == START_ADDR) ? END_ADDR : (r_count - ONE);
      end
    end else begin
      w_next_count = r_count;
    end
  end

  // Count register, parked on the first word of the region after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= START_ADDR;
    end else begin
      r_count <= w_next_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/flash_word_reader.sv
// Fetches one 32-bit flash word per audio_control request over Avalon-MM,
// walking the sample region forward or backward with wrap-around.
module flash_word_reader
  import audio_pkg::*;
#(
  parameter int                ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = audio_pkg::START_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR   = audio_pkg::END_ADDR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    word_req,
  input  logic                    play_audio,
  input  logic                    forward,
  input  logic                    restart,
  flash_word_reader_if.master     flash,
  output logic [FLASH_WORD_W-1:0] data_out,
  output logic                    data_valid
);

  reader_state_t           r_state;
  reader_state_t           w_next_state;
  logic                    r_pending;
  logic                    w_pending_nxt;
  logic                    r_restart;
  logic                    w_restart_nxt;
  logic                    r_flash_read;
  logic [FLASH_WORD_W-1:0] r_data_out;
  logic                    r_data_valid;

  logic                    w_latch;
  logic                    w_idle_like;
  logic                    w_in_flight;
  logic                    w_load;
  logic [ADDR_W-1:0]       w_load_val;
  logic [ADDR_W-1:0]       w_addr;

  // A word lands only while waiting for it; stray data-valids are ignored
  assign w_latch     = (r_state == WAIT_DATA) && flash.flash_readdatavalid;
  // No transaction outstanding: a restart can reload immediately
  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  // A transaction is outstanding: a restart must wait for the latch
  assign w_in_flight = (r_state == READ) || (r_state == WAIT_DATA);
  assign w_load_val  = forward ? START_ADDR : END_ADDR;
  // Reload replaces the step at the latch edge, or applies at once when idle
  assign w_load      = (w_latch && (restart || r_restart)) || (restart && w_idle_like);

  wrap_addr_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .step     (w_latch),
    .up       (forward),
    .load     (w_load),
    .load_val (w_load_val),
    .count    (w_addr)
  );

  // Next-state decode for the fetch sequence
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if ((word_req || r_pending) && play_audio) begin
          w_next_state = READ;
        end else begin
          w_next_state = IDLE;
        end
      end
      READ: begin
        if (!flash.flash_waitrequest) begin
          w_next_state = WAIT_DATA;
        end else begin
          w_next_state = READ;
        end
      end
      WAIT_DATA: begin
        if (flash.flash_readdatavalid) begin
          w_next_state = DONE;
        end else begin
          w_next_state = WAIT_DATA;
        end
      end
      DONE: begin
        if (r_pending && play_audio) begin
          w_next_state = READ;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // One-deep request memory: cleared on entering READ, resolved in DONE
  always_comb begin
    w_pending_nxt = r_pending;
    if ((w_next_state == READ) && (r_state != READ)) begin
      w_pending_nxt = 1'b0;
    end else if (r_state == DONE) begin
      w_pending_nxt = word_req && play_audio;
    end else if (word_req && w_in_flight) begin
      w_pending_nxt = 1'b1;
    end else begin
      w_pending_nxt = r_pending;
    end
  end

  // Restart seen mid-transaction is held until the word is latched
  always_comb begin
    w_restart_nxt = r_restart;
    if (w_latch) begin
      w_restart_nxt = 1'b0;
    end else if (restart && w_in_flight) begin
      w_restart_nxt = 1'b1;
    end else begin
      w_restart_nxt = r_restart;
    end
  end

  // FSM state and control flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_pending_nxt;
      r_restart <= w_restart_nxt;
    end
  end

  // Registered outputs: read strobe tracks READ, data pulse tracks DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flash_read <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_out   <= {FLASH_WORD_W{1'b0}};
    end else begin
      r_flash_read <= (w_next_state == READ);
      r_data_valid <= (w_next_state == DONE);
      if (w_latch) begin
        r_data_out <= flash.flash_readdata;
      end else begin
        r_data_out <= r_data_out;
      end
    end
  end

  assign flash.flash_read       = r_flash_read;
  assign flash.flash_address    = w_addr;
  assign flash.flash_byteenable = full_word_byteenable();
  assign data_out               = r_data_out;
  assign data_valid             = r_data_valid;

endmodule
